// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_ctrl
// Brief    : Single-clock parametrised FIFO for the UART TX/RX data paths, with
//            occupancy count, programmable almost-full/almost-empty thresholds,
//            sticky overflow/underflow flags and synchronous flush.
//            Define UART_FIFO_FWFT_EN for first-word-fall-through reads;
//            otherwise reads are registered with one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] c_ptr_one    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_cnt_one    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_cnt_full   = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flush overrides both requests, so neither transfers nor raises an error.
  always_comb begin
    wr_acc = wr_en & ~full_q & ~flush;
    rd_acc = rd_en & ~empty_q & ~flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + c_ptr_one;
      if (rd_acc) rd_ptr_d = rd_ptr_q + c_ptr_one;
      if (wr_acc && !rd_acc) begin
        count_d = count_q + c_cnt_one;
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - c_cnt_one;
      end
    end

    // Flags look ahead at the next occupancy so they line up with count.
    if (flush) begin
      full_d         = 1'b0;
      empty_d        = 1'b1;
      almost_full_d  = 1'b0;
      almost_empty_d = 1'b1;
    end else begin
      full_d         = (count_d == c_cnt_full);
      empty_d        = (count_d == '0);
      almost_full_d  = (count_d >= af_thresh);
      almost_empty_d = (count_d <= ae_thresh);
    end

    overflow_d  = (wr_en & full_q & ~flush)  | (overflow_q  & ~err_clr);
    underflow_d = (rd_en & empty_q & ~flush) | (underflow_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

`ifdef UART_FIFO_FWFT_EN
  // Head word is shown directly; zero while empty so no stale data leaks out.
  assign rd_data  = empty_q ? '0 : mem[rd_ptr_q];
  assign rd_valid = ~empty_q;
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  always_comb begin
    rd_data_d  = rd_acc ? mem[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_ctrl
// Brief    : Self-checking bench for uart_fifo_ctrl: queue-based reference
//            model compared every cycle, directed scenarios, random traffic.
//            Honours UART_FIFO_FWFT_EN for the read-port expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [AW:0]   af_thresh = 5'd14;
  logic [AW:0]   ae_thresh = 5'd2;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  uart_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, registered outputs as plain bits.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid, m_full, m_empty, m_af, m_ae, m_ovf, m_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_full     = 1'b0;
    m_empty    = 1'b1;
    m_af       = 1'b0;
    m_ae       = 1'b1;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  endtask

  task automatic model_edge();
    int  n;
    bit  w, r, set_o, set_u;
    n     = q.size();
    set_o = !flush && wr_en && (n == DEPTH);
    set_u = !flush && rd_en && (n == 0);
    m_ovf = set_o || (m_ovf && !err_clr);
    m_udf = set_u || (m_udf && !err_clr);
    if (flush) begin
      q.delete();
      m_rd_valid = 1'b0;
      m_full     = 1'b0;
      m_empty    = 1'b1;
      m_af       = 1'b0;
      m_ae       = 1'b1;
    end else begin
      w = wr_en && (n < DEPTH);
      r = rd_en && (n > 0);
      if (r) m_rd_data = q.pop_front();
      m_rd_valid = r;
      if (w) q.push_back(wr_data);
      n       = q.size();
      m_full  = (n == DEPTH);
      m_empty = (n == 0);
      m_af    = (n >= int'(af_thresh));
      m_ae    = (n <= int'(ae_thresh));
    end
  endtask

  task automatic compare_all();
    chk("count", count, q.size());
    chk("full", full, m_full);
    chk("empty", empty, m_empty);
    chk("almost_full", almost_full, m_af);
    chk("almost_empty", almost_empty, m_ae);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
`ifdef UART_FIFO_FWFT_EN
    chk("rd_valid", rd_valid, q.size() != 0);
    if (q.size() != 0) chk("rd_data", rd_data, q[0]);
`else
    chk("rd_valid", rd_valid, m_rd_valid);
    chk("rd_data", rd_data, m_rd_data);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_rd_data", rd_data, 0);
    rst = 1'b1;
    step();

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = DW'(i);
      step();
      if (i == 13) chk("af_at_13", almost_full, 0);
      if (i == 14) chk("af_at_14", almost_full, 1);
    end
    wr_en = 1'b0;
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);

    // Overflow while full, then clear
    wr_en = 1'b1; wr_data = 8'hAA;
    step();
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Drain: expect 0x01..0x10 in order, 0xAA never appears
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
`ifdef UART_FIFO_FWFT_EN
      chk("drain_head", rd_data, i + 1);
      step();
`else
      step();
      chk("drain_data", rd_data, i + 1);
      chk("drain_valid", rd_valid, 1);
`endif
    end
    rd_en = 1'b0;
    step();
    chk("drain_empty", empty, 1);
`ifndef UART_FIFO_FWFT_EN
    chk("drain_valid_off", rd_valid, 0);
`endif
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("udf_set", underflow, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

`ifdef UART_FIFO_FWFT_EN
    // Fall-through: written word appears without rd_en, then popped
    wr_en = 1'b1; wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    chk("fwft_valid", rd_valid, 1);
    chk("fwft_data", rd_data, 8'h5A);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("fwft_pop_empty", empty, 1);
`endif

    // Hold count at 8 with simultaneous traffic across pointer wrap
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = DW'(8'h20 + i);
      step();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wr_data = DW'(8'h28 + k);
      step();
      chk("wrap_count", count, 8);
`ifndef UART_FIFO_FWFT_EN
      chk("wrap_data", rd_data, 8'h20 + k);
`endif
    end
    wr_en = 1'b0;
    repeat (8) step();
    rd_en = 1'b0;
    step();

    // Flush with concurrent write at count 5
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = DW'(8'h40 + i);
      step();
    end
    flush = 1'b1; wr_data = 8'h77;
    step();
    flush = 1'b0; wr_en = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);

    // Random traffic with an asynchronous reset mid-burst
    for (int c = 0; c < 3000; c++) begin
      int ph;
      if (c == 1500) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_rst_count", count, 0);
        chk("async_rst_valid", rd_valid, 0);
        @(negedge clk);
        rst = 1'b1;
      end
      ph      = (c / 150) % 3;
      wr_en   = ($urandom_range(99) < ((ph == 0) ? 80 : (ph == 1) ? 20 : 50));
      rd_en   = ($urandom_range(99) < ((ph == 0) ? 20 : (ph == 1) ? 80 : 50));
      wr_data = DW'($urandom);
      flush   = ($urandom_range(63) == 0);
      err_clr = ($urandom_range(15) == 0);
      if ($urandom_range(31) == 0) af_thresh = (AW+1)'($urandom_range(31));
      if ($urandom_range(31) == 0) ae_thresh = (AW+1)'($urandom_range(31));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
